screen_painter: RTL and testbench
=================================

Name: screen_painter

Overview:
- Sweep engine placed directly upstream of the per-screen VGA adapter instances. It drives x, y, colour and plot so that a full 160x120 background image is written into adapter video memory.
- On a start pulse it latches a screen select and walks every pixel in raster order.
- For each pixel it fetches the 3-bit colour from an external synchronous image ROM holding all six screens back to back, then plots that pixel one cycle later.
- It reports busy/done back to the game controller.

Parameters:
- H_RES, 160, pixels per row
- V_RES, 120, rows per frame
- NUM_SCREENS, 6, images in ROM (0 title, 1 idle, 2 pause, 3 countdown, 4 A_won, 5 B_won)
- ADDR_W, 17, ROM address width (must satisfy 2^ADDR_W >= NUM_SCREENS*H_RES*V_RES = 115200)

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to paint a screen
- screen_sel  in  3  screen index, sampled only in the cycle start is high
- abort  in  1  stops an in-progress sweep
- rom_addr  out  ADDR_W  address to image ROM, registered
- rom_q  in  3  ROM data, valid exactly 1 cycle after rom_addr
- x  out  8  pixel column to adapter
- y  out  7  pixel row to adapter
- colour  out  3  pixel colour {R,G,B} to adapter
- plot  out  1  write strobe to adapter
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses
- done  out  1  single-cycle pulse when the last pixel has been plotted

Behaviour:
- Reset (async, active-high): state=IDLE; rom_addr=0, x=0, y=0, colour=0, plot=0, busy=0, done=0; sweep counters=0.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - start=1 with screen_sel < NUM_SCREENS: latch base = screen_sel*H_RES*V_RES (constant lookup, no multiplier), go to SWEEP. Cycle k is the start edge.
  - start=1 with screen_sel >= NUM_SCREENS: ignored, stay IDLE, no output change.
- SWEEP:
  - At k+1: rom_addr=base, cx=0, cy=0, busy=1.
  - Each cycle: rom_addr increments by 1. cx increments; at cx=H_RES-1 it wraps to 0 and cy increments.
  - Issuing address (H_RES-1, V_RES-1) moves the state to DRAIN.
- Pixel pipeline: 1-stage delay register holds (cx, cy, valid). In the cycle after an address is issued: plot=1, x/y = delayed cx/cy, colour=rom_q.
  - First plot at cycle k+2 with (0,0).
  - Last plot at cycle k+19201 with (159,119).
  - plot is high for exactly 19200 consecutive cycles.
- DRAIN: one cycle in which the final pixel is plotted, then go to DONE.
- DONE: done=1 for exactly one cycle (k+19202), busy=0 in the same cycle, then return to IDLE.
- x, y, colour hold their last values when plot=0. rom_addr holds its last value outside SWEEP.
- start while busy: ignored. screen_sel changes mid-sweep have no effect.
- abort=1 in SWEEP or DRAIN:
  - Next cycle: plot=0, the pending pipeline pixel is discarded, state=IDLE, busy=0, done stays 0.
  - abort has priority over a same-cycle start.
  - abort in IDLE or DONE has no effect.
- start in the DONE cycle: ignored. A new start is accepted from the following IDLE cycle.
- Reset mid-sweep: immediate return to reset values; no further plot.
- Width rule: base+offset stays below 115200, so rom_addr never wraps. cx and cy never exceed H_RES-1 and V_RES-1.

Decomposition:
- Shared package screen_pkg holds:
  - H_RES and V_RES
  - the SCREEN_TITLE..SCREEN_B_WON index constants
  - the SCREEN_BASE[0..5] address constants (0, 19200, 38400, 57600, 76800, 96000)
  - the state encoding
- One natural sub-module: raster_counter (cx/cy/address counter with wrap and last-pixel flag). The FSM and pixel pipeline stay in screen_painter.

Test Plan:
- Reset, then start=1 with screen_sel=0 and a ROM model returning addr[2:0] -> first plot at k+2 with x=0, y=0, colour=0. Exactly 19200 plots. Last plot (159,119) with colour=(19199 mod 8)=7. done at k+19202.
- screen_sel=5 -> first rom_addr=96000, last rom_addr=115199. Plotted colours match the ROM model for every pixel.
- Row wrap: monitor the plot after (159,0) -> next plot is (0,1) with rom_addr offset 160 and no gap cycle.
- start with screen_sel=6 and with screen_sel=7 -> busy stays 0, no plot, no done, rom_addr unchanged.
- abort at the 500th plot -> 500 plots seen and at most one more, then plot=0 from the next cycle, busy=0, done never pulses. A new start then paints a full 19200 pixels.
- start pulse mid-sweep with a different screen_sel, and async reset asserted mid-sweep -> the first is ignored (image unchanged). The reset drives plot=0, busy=0, x=0, y=0 immediately, and no done pulse follows.

Source files
------------

// File: rtl/screen_painter_pkg.sv
// Shared definitions for the screen painter: raster geometry, screen indices,
// per-screen ROM base addresses and the sweep state encoding.
package screen_pkg;

  localparam int H_RES       = 160;
  localparam int V_RES       = 120;
  localparam int NUM_SCREENS = 6;
  localparam int ADDR_W      = 17;
  localparam int X_W         = 8;
  localparam int Y_W         = 7;
  localparam int COLOUR_W    = 3;
  localparam int SEL_W       = 3;

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  localparam logic [SEL_W-1:0] SCREEN_TITLE     = 3'd0;
  localparam logic [SEL_W-1:0] SCREEN_IDLE      = 3'd1;
  localparam logic [SEL_W-1:0] SCREEN_PAUSE     = 3'd2;
  localparam logic [SEL_W-1:0] SCREEN_COUNTDOWN = 3'd3;
  localparam logic [SEL_W-1:0] SCREEN_A_WON     = 3'd4;
  localparam logic [SEL_W-1:0] SCREEN_B_WON     = 3'd5;

  // Images are stored back to back, one 160x120 frame each.
  localparam logic [ADDR_W-1:0] SCREEN_BASE [NUM_SCREENS] = '{
    17'd0, 17'd19200, 17'd38400, 17'd57600, 17'd76800, 17'd96000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    return sel <= SEL_W'(NUM_SCREENS - 1);
  endfunction

  function automatic logic [ADDR_W-1:0] screen_base(input logic [SEL_W-1:0] sel);
    case (sel)
      SCREEN_TITLE:     return SCREEN_BASE[0];
      SCREEN_IDLE:      return SCREEN_BASE[1];
      SCREEN_PAUSE:     return SCREEN_BASE[2];
      SCREEN_COUNTDOWN: return SCREEN_BASE[3];
      SCREEN_A_WON:     return SCREEN_BASE[4];
      SCREEN_B_WON:     return SCREEN_BASE[5];
      default:          return '0;
    endcase
  endfunction

endpackage

// File: rtl/screen_painter_if.sv
// Control, image-ROM and VGA-adapter signals of the screen painter.
interface screen_painter_if;
  import screen_pkg::*;

  logic                start;
  logic [SEL_W-1:0]    screen_sel;
  logic                abort;
  logic [ADDR_W-1:0]   rom_addr;
  logic [COLOUR_W-1:0] rom_q;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    input  start, screen_sel, abort, rom_q,
    output rom_addr, x, y, colour, plot, busy, done
  );

  modport slave (
    output start, screen_sel, abort, rom_q,
    input  rom_addr, x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/screen_painter_raster.sv
// Raster-order pixel counter: column/row position, ROM address and a flag
// marking the final pixel of the frame.
module raster_counter
  import screen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  output logic [X_W-1:0]    cx,
  output logic [Y_W-1:0]    cy,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [X_W-1:0]    cx_q, cx_d;
  logic [Y_W-1:0]    cy_q, cy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_pix;

  assign last_pix = (cx_q == X_LAST) && (cy_q == Y_LAST);

  always_comb begin
    cx_d   = cx_q;
    cy_d   = cy_q;
    addr_d = addr_q;
    if (load) begin
      cx_d   = '0;
      cy_d   = '0;
      addr_d = base;
    end else if (advance && !last_pix) begin
      addr_d = addr_q + ADDR_W'(1);
      if (cx_q == X_LAST) begin
        cx_d = '0;
        cy_d = cy_q + Y_W'(1);
      end else begin
        cx_d = cx_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx_q   <= '0;
      cy_q   <= '0;
      addr_q <= '0;
    end else begin
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      addr_q <= addr_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign addr = addr_q;
  assign last = last_pix;

endmodule

// File: rtl/screen_painter.sv
// Paints a full background image from the image ROM into the VGA adapter,
// one pixel per cycle in raster order, with busy/done reporting and abort.
module screen_painter
  import screen_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              reset,
  screen_painter_if.master  bus
);

  state_e              state_q, state_d;
  logic                load, advance, issue;
  logic [X_W-1:0]      cx;
  logic [Y_W-1:0]      cy;
  logic [ADDR_W-1:0]   addr;
  logic                last;

  logic                vld_p1_q, vld_p1_d;
  logic [X_W-1:0]      x_p1_q, x_p1_d;
  logic [Y_W-1:0]      y_p1_q, y_p1_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [COLOUR_W-1:0] colour_out;

  raster_counter u_raster (
    .clk     (CLOCK_50),
    .rst     (reset),
    .load    (load),
    .advance (advance),
    .base    (screen_base(bus.screen_sel)),
    .cx      (cx),
    .cy      (cy),
    .addr    (addr),
    .last    (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && sel_valid(bus.screen_sel)) begin
          load    = 1'b1;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          issue = 1'b1;
          if (last) state_d = DRAIN;
          else      advance = 1'b1;
        end
      end
      DRAIN: state_d = bus.abort ? IDLE : DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: the address issued this cycle becomes a plotted pixel next
  // cycle, when the ROM word for it arrives on rom_q.
  always_comb begin
    vld_p1_d = issue;
    x_p1_d   = issue ? cx : x_p1_q;
    y_p1_d   = issue ? cy : y_p1_q;
    colour_d = colour_out;
  end

  assign colour_out = vld_p1_q ? bus.rom_q : colour_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      vld_p1_q <= 1'b0;
      x_p1_q   <= '0;
      y_p1_q   <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      vld_p1_q <= vld_p1_d;
      x_p1_q   <= x_p1_d;
      y_p1_q   <= y_p1_d;
      colour_q <= colour_d;
    end
  end

  assign bus.rom_addr = addr;
  assign bus.x        = x_p1_q;
  assign bus.y        = y_p1_q;
  assign bus.colour   = colour_out;
  assign bus.plot     = vld_p1_q;
  assign bus.busy     = (state_q == SWEEP) || (state_q == DRAIN);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_screen_painter.sv
// Directed bench for screen_painter: full paints, row wrap, invalid selects,
// abort, mid-sweep start and asynchronous reset mid-sweep.
module tb_screen_painter;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   rom_mode = 0;

  screen_painter_if bus();

  screen_painter dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_fn(input logic [16:0] a);
    if (rom_mode != 0) return a[2:0] ^ a[10:8];
    return a[2:0];
  endfunction

  always @(posedge clk) bus.rom_q <= rom_fn(bus.rom_addr);

  function automatic int base_of(input int sel);
    case (sel)
      0: return 0;
      1: return 19200;
      2: return 38400;
      3: return 57600;
      4: return 76800;
      default: return 96000;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.screen_sel = 3'd0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: plot/busy/done=%b expected 000", {bus.plot, bus.busy, bus.done});
    end
    vectors++;
    if (bus.rom_addr !== 17'd0 || bus.x !== 8'd0 || bus.y !== 7'd0 || bus.colour !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%0d x=%0d y=%0d colour=%0d expected all 0",
               bus.rom_addr, bus.x, bus.y, bus.colour);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bad_sel();
    for (int s = 6; s <= 7; s++) begin
      bus.start = 1'b1;
      bus.screen_sel = 3'(s);
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        vectors++;
        if ({bus.busy, bus.plot, bus.done} !== 3'b000 || bus.rom_addr !== 17'd0) begin
          miscompares++;
          $display("FAIL bad_sel_%0d: busy/plot/done=%b addr=%0d expected 000 addr=0",
                   s, {bus.busy, bus.plot, bus.done}, bus.rom_addr);
        end
        @(negedge clk);
      end
    end
  endtask

  // Paints screen 'sel' and checks every pixel. Optional events at plot index n:
  // abort_at (abort + same-cycle start), mid_at (start with another select),
  // rst_at (async reset). Negative values disable an event.
  task automatic paint(input int sel, input int abort_at, input int mid_at, input int rst_at);
    int base, bad, first_bad, plots;
    logic [16:0] ea;
    bad = 0; first_bad = -1; plots = 0;
    base = base_of(sel);
    bus.start = 1'b1;
    bus.screen_sel = 3'(sel);
    @(negedge clk);
    bus.start = 1'b0;
    bus.screen_sel = 3'd0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.plot !== 1'b0 || bus.rom_addr !== 17'(base)) begin
      miscompares++;
      $display("FAIL start_s%0d: busy=%b plot=%b addr=%0d expected busy=1 plot=0 addr=%0d",
               sel, bus.busy, bus.plot, bus.rom_addr, base);
    end
    for (int n = 0; n < 19200; n++) begin
      @(negedge clk);
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.x !== 8'd0 || bus.y !== 7'd0 || bus.rom_addr !== 17'd0) begin
          miscompares++;
          $display("FAIL async_reset: plot=%b busy=%b x=%0d y=%0d addr=%0d expected 0s",
                   bus.plot, bus.busy, bus.x, bus.y, bus.rom_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          vectors++;
          if (bus.plot !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: plot=%b done=%b busy=%b expected 0 0 0", bus.plot, bus.done, bus.busy);
          end
        end
        return;
      end
      if (bus.plot === 1'b1) plots++;
      ea = (n < 19199) ? 17'(base + n + 1) : 17'(base + 19199);
      if (bus.plot !== 1'b1 || bus.x !== 8'(n % 160) || bus.y !== 7'(n / 160) ||
          bus.colour !== rom_fn(17'(base + n)) || bus.rom_addr !== ea ||
          bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = n;
      end
      if (n == 159) begin
        vectors++;
        if (bus.x !== 8'd159 || bus.y !== 7'd0 || bus.rom_addr !== 17'(base + 160)) begin
          miscompares++;
          $display("FAIL row_end: x=%0d y=%0d addr=%0d expected 159 0 %0d", bus.x, bus.y, bus.rom_addr, base + 160);
        end
      end
      if (n == 160) begin
        vectors++;
        if (bus.plot !== 1'b1 || bus.x !== 8'd0 || bus.y !== 7'd1) begin
          miscompares++;
          $display("FAIL row_wrap: plot=%b x=%0d y=%0d expected 1 0 1", bus.plot, bus.x, bus.y);
        end
      end
      if (n == 19199) begin
        vectors++;
        if (bus.x !== 8'd159 || bus.y !== 7'd119 || bus.colour !== rom_fn(17'(base + 19199)) ||
            bus.rom_addr !== 17'(base + 19199)) begin
          miscompares++;
          $display("FAIL last_pixel: x=%0d y=%0d colour=%0d addr=%0d expected 159 119 %0d %0d",
                   bus.x, bus.y, bus.colour, bus.rom_addr, rom_fn(17'(base + 19199)), base + 19199);
        end
      end
      if (n == mid_at) begin
        bus.start = 1'b1;
        bus.screen_sel = 3'((sel + 1) % 6);
      end
      if (n == mid_at + 1) begin
        bus.start = 1'b0;
        bus.screen_sel = 3'd0;
      end
      if (n == abort_at) begin
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.screen_sel = 3'(sel);
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        vectors++;
        if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_stop: plot=%b busy=%b done=%b expected 0 0 0", bus.plot, bus.busy, bus.done);
        end
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (bus.plot === 1'b1) plots++;
          if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        vectors++;
        if (plots != abort_at + 1 || bad != 0) begin
          miscompares++;
          $display("FAIL abort_count: plots=%0d bad=%0d expected %0d 0", plots, bad, abort_at + 1);
        end
        return;
      end
    end
    vectors++;
    if (bad != 0 || plots != 19200) begin
      miscompares++;
      $display("FAIL pixels_s%0d: bad=%0d first_bad=%0d plots=%0d expected bad=0 plots=19200",
               sel, bad, first_bad, plots);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.plot !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b busy=%b plot=%b expected 1 0 0", bus.done, bus.busy, bus.plot);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.x !== 8'd159 || bus.y !== 7'd119) begin
      miscompares++;
      $display("FAIL after_done: done=%b busy=%b x=%0d y=%0d expected 0 0 159 119",
               bus.done, bus.busy, bus.x, bus.y);
    end
  endtask

  task automatic test_screen0();
    rom_mode = 0;
    paint(0, -1, -1, -1);
  endtask

  task automatic test_screen5();
    rom_mode = 1;
    paint(5, -1, -1, -1);
  endtask

  task automatic test_abort();
    rom_mode = 1;
    paint(2, 499, -1, -1);
    paint(2, -1, -1, -1);
  endtask

  task automatic test_midstart_reset();
    rom_mode = 1;
    paint(1, -1, 1000, 3000);
  endtask

  initial begin
    test_reset();
    test_bad_sel();
    test_screen0();
    test_screen5();
    test_abort();
    test_midstart_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
